ascii_write_unpacker: RTL
=========================

Name: ascii_write_unpacker

Overview:
- Sits between the processor's memory-mapped VGA write port and the character RAM inside the ASCII display controller.
- Accepts byte, half-word and word stores, each carrying 1–4 ASCII characters, and queues them in a small FIFO.
- Unpacks each store into single-character writes, one per accepted cycle, with back-pressure from the character RAM.
- Lets the processor issue word stores to the text screen without losing characters.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 13, character address width
- NUM_CHARS, 4800, valid character cells (80x60); addresses ≥ NUM_CHARS are out of range

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  store request; one store per cycle while high
- in_ready  output  1  FIFO not full; a store is accepted when in_valid & in_ready
- in_addr  input  ADDR_W  byte address of the first character
- in_size  input  2  01 byte, 10 half-word, 11 word; 00 is ignored (not pushed)
- in_data  input  32  characters, little-endian (bits 7:0 go to in_addr)
- char_we  output  1  character write valid
- char_ready  input  1  RAM accepts the write this cycle
- char_addr  output  ADDR_W  character cell address
- char_data  output  8  ASCII code
- busy  output  1  FIFO non-empty or unpack in progress
- overflow_err  output  1  sticky: in_valid with nonzero size seen while in_ready=0 (store dropped)
- range_err  output  1  sticky: a character was suppressed because its address ≥ NUM_CHARS

Behaviour:
- Reset (rst=0, async):
  - FIFO empties; FSM goes to IDLE.
  - in_ready=1; char_we=0; char_addr=0; char_data=0; busy=0; overflow_err=0; range_err=0.
  - Work in progress is discarded; no partial write completes after reset.
- FIFO:
  - Entries are {addr, size, data}; count register runs 0..DEPTH.
  - in_ready = (count != DEPTH), registered and derived from count.
  - A push and a pop in the same cycle leave count unchanged, including when count=DEPTH.
  - A push with in_size=00 is dropped silently and does not set overflow_err.
- FSM states:
  - IDLE:
    - If FIFO is non-empty: pop the head into hold registers, set idx=0, set nbytes=1/2/4 from size, go to LOAD.
    - Otherwise stay in IDLE.
  - LOAD:
    - If hold_addr+idx < NUM_CHARS: present char_we=1, char_addr=hold_addr+idx, char_data=hold_data[8*idx+:8], go to EMIT.
    - Otherwise: set range_err, increment idx, and go to IDLE if idx was the last byte, else stay in LOAD.
  - EMIT:
    - Outputs are held stable while char_ready=0.
    - On char_ready=1: drop char_we, increment idx.
    - Then go to LOAD if bytes remain, else IDLE.
- Address arithmetic:
  - hold_addr+idx is computed at ADDR_W+1 bits, so there is no wrap.
  - Misaligned addresses are legal; characters go to consecutive cells.
- Latency:
  - Store accepted in cycle N (FIFO write at the N edge).
  - IDLE pops at N+1; LOAD at N+2; first char_we=1 visible in cycle N+3.
  - With char_ready held high, a word store produces 4 writes spaced 2 cycles apart.
- busy = (count != 0) | (state != IDLE).
- Sticky errors clear only on reset.

Decomposition:
- Shared package ascii_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state encoding: IDLE/LOAD/EMIT.
  - Text geometry constants COLS=80, ROWS=60, NUM_CHARS.
- One sub-module: sync_fifo.
  - Parameterised width/depth; async active-low reset.
  - Ports: push, pop, din, dout, count, full, empty.
  - The unpack FSM lives in ascii_write_unpacker.

Test Plan:
- Word store, addr=0x010, data=0x44434241, char_ready=1 → writes (0x010,'A'), (0x011,'B'), (0x012,'C'), (0x013,'D') in order; first char_we in cycle N+3; busy falls after the last write.
- Half-word at addr=0x12BF (4799), data=0x00005A59 → one write (0x12BF,'Y'); 'Z' suppressed; range_err=1.
- Five back-to-back word stores with char_ready=0:
  - in_ready drops after the 4th pop-adjusted fill.
  - A store presented while in_ready=0 sets overflow_err=1 and is dropped.
  - After char_ready=1, exactly the accepted stores drain.
- Stall mid-word: char_ready low for 5 cycles on the 2nd byte → char_addr/char_data held constant; no duplicate or skipped characters.
- Reset asserted during EMIT of byte 2 of 4 → char_we=0 immediately, busy=0, errors cleared; after release, a new byte store (0x000,'H') emits normally.
- in_size=00 with in_valid=1 → no FIFO entry, no writes, no error flags.

Source files
------------

// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII text-screen write path: store size codes,
// unpacker state encoding and the 80x60 screen geometry.
package ascii_pkg;

    localparam int COLS      = 80;
    localparam int ROWS      = 60;
    localparam int NUM_CHARS = COLS * ROWS;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_e;

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_to_nbytes = 3'd1;
            SZ_HALF: size_to_nbytes = 3'd2;
            SZ_WORD: size_to_nbytes = 3'd4;
            default: size_to_nbytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, combinational read of the head entry, no output register.
// Latency: pushed data visible at dout the cycle after the push. Push while full is taken only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A full FIFO can still take a write into the slot being vacated this cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ascii_write_unpacker.sv
// Queues 1/2/4-character processor stores and replays them as single-character RAM writes.
// Latency: first char_we three cycles after acceptance. char_ready low holds the write; in_ready drops when the queue is full.
module ascii_write_unpacker
    import ascii_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 13,
    parameter int NUM_CHARS = ascii_pkg::NUM_CHARS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_size,
    input  logic [31:0]       in_data,
    output logic              char_we,
    input  logic              char_ready,
    output logic [ADDR_W-1:0] char_addr,
    output logic [7:0]        char_data,
    output logic              busy,
    output logic              overflow_err,
    output logic              range_err
);
    localparam int FW = ADDR_W + 2 + 32;
    localparam logic [ADDR_W:0] CHAR_LIMIT = (ADDR_W+1)'(NUM_CHARS);

    logic [FW-1:0]           fifo_dout;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_full, fifo_empty;
    logic                    push, pop;
    logic [ADDR_W-1:0]       fifo_addr;
    logic [1:0]              fifo_size;
    logic [31:0]             fifo_data;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       hold_addr_q, hold_addr_d;
    logic [31:0]             hold_data_q, hold_data_d;
    logic [2:0]              nbytes_q, nbytes_d;
    logic [2:0]              idx_q, idx_d;
    logic                    char_we_q, char_we_d;
    logic [ADDR_W-1:0]       char_addr_q, char_addr_d;
    logic [7:0]              char_data_q, char_data_d;
    logic                    overflow_err_q, overflow_err_d;
    logic                    range_err_q, range_err_d;

    logic [ADDR_W:0]         cur_addr;
    logic [2:0]              idx_nxt;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & ~fifo_full & (in_size != SZ_NONE);
    assign {fifo_addr, fifo_size, fifo_data} = fifo_dout;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({in_addr, in_size, in_data}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Widened by one bit so a store near the top of the address space never wraps into range.
    assign cur_addr = {1'b0, hold_addr_q} + (ADDR_W+1)'(idx_q);
    assign idx_nxt  = idx_q + 3'd1;

    always_comb begin
        state_d        = state_q;
        hold_addr_d    = hold_addr_q;
        hold_data_d    = hold_data_q;
        nbytes_d       = nbytes_q;
        idx_d          = idx_q;
        char_we_d      = char_we_q;
        char_addr_d    = char_addr_q;
        char_data_d    = char_data_q;
        range_err_d    = range_err_q;
        overflow_err_d = overflow_err_q | (in_valid & fifo_full & (in_size != SZ_NONE));
        pop            = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    hold_addr_d = fifo_addr;
                    hold_data_d = fifo_data;
                    nbytes_d    = size_to_nbytes(fifo_size);
                    idx_d       = 3'd0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (cur_addr < CHAR_LIMIT) begin
                    char_we_d   = 1'b1;
                    char_addr_d = cur_addr[ADDR_W-1:0];
                    char_data_d = hold_data_q[{idx_q[1:0], 3'b000} +: 8];
                    state_d     = EMIT;
                end else begin
                    range_err_d = 1'b1;
                    idx_d       = idx_nxt;
                    if (idx_nxt >= nbytes_q) state_d = IDLE;
                end
            end
            EMIT: begin
                if (char_ready) begin
                    char_we_d = 1'b0;
                    idx_d     = idx_nxt;
                    state_d   = (idx_nxt < nbytes_q) ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            hold_addr_q    <= '0;
            hold_data_q    <= '0;
            nbytes_q       <= '0;
            idx_q          <= '0;
            char_we_q      <= 1'b0;
            char_addr_q    <= '0;
            char_data_q    <= '0;
            overflow_err_q <= 1'b0;
            range_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_addr_q    <= hold_addr_d;
            hold_data_q    <= hold_data_d;
            nbytes_q       <= nbytes_d;
            idx_q          <= idx_d;
            char_we_q      <= char_we_d;
            char_addr_q    <= char_addr_d;
            char_data_q    <= char_data_d;
            overflow_err_q <= overflow_err_d;
            range_err_q    <= range_err_d;
        end
    end

    assign char_we      = char_we_q;
    assign char_addr    = char_addr_q;
    assign char_data    = char_data_q;
    assign overflow_err = overflow_err_q;
    assign range_err    = range_err_q;
    assign busy         = (fifo_count != '0) | (state_q != IDLE);

endmodule
